// File: rtl/f_prefetch_buffer.sv
// f_prefetch_buffer
//   Fetch stage sitting between instruction memory and decode. It issues
//   sequential word-aligned fetch requests, keeps returned words in a
//   DEPTH-entry in-order queue, and hands {pc, instr} pairs to decode.
//   A branch redirect flushes the queue and marks every in-flight response
//   as stale so it is discarded on arrival.
//
// Ports
//   clock, reset      : single clock, asynchronous active-high reset
//   imem_req_valid/ready/addr : fetch request channel (out/in/out)
//   imem_rsp_valid/data       : in-order response channel (in/in)
//   f_valid, f_pc_o, instr    : queue head offered to decode (out)
//   d_ready                   : decode accepts the head this cycle (in)
//   br_en, br_addr            : redirect request and target (in)
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. A request, once raised, holds valid and address stable until
// it is accepted, except in a br_en cycle which withdraws it. Responses
// carry no ready; they are always accepted (pushed or discarded).
module f_prefetch_buffer #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            f_valid,
  output logic [XLEN-1:0] f_pc_o,
  output logic [XLEN-1:0] instr,
  input  logic            d_ready,
  input  logic            br_en,
  input  logic [XLEN-1:0] br_addr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [SW-1:0]   occ;
  logic            req_fire;
  logic            push;
  logic            pop;

  // Issue / output logic
  always_comb begin
    // Queue entries plus non-stale in-flight requests: each of those will
    // need a slot, so this sum must stay below DEPTH to issue another.
    occ            = SW'(count_q) + SW'(out_cnt_q - drop_cnt_q);
    imem_req_valid = !reset && !br_en && (out_cnt_q < OW'(MAX_OUT)) &&
                     (occ < SW'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    f_valid        = (count_q != '0);
    f_pc_o         = f_valid ? pc_mem[head_q]    : '0;
    instr          = f_valid ? instr_mem[head_q] : '0;
    req_fire       = imem_req_valid && imem_req_ready;
    pop            = f_valid && d_ready && !br_en;
    push           = imem_rsp_valid && (drop_cnt_q == '0) && !br_en;
  end

  // Next-state logic
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (br_en) begin
      fetch_pc_d = {br_addr[XLEN-1:2], 2'b00};
      rsp_pc_d   = {br_addr[XLEN-1:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      // Everything still outstanding after this edge is stale; a response
      // arriving right now is simply discarded.
      out_cnt_d  = out_cnt_q - OW'(imem_rsp_valid);
      drop_cnt_d = out_cnt_q - OW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      out_cnt_d = out_cnt_q + OW'(req_fire) - OW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - OW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        tail_d   = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while count > 0.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[tail_q]    <= rsp_pc_q;
      instr_mem[tail_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_f_prefetch_buffer.sv
// Testbench for f_prefetch_buffer: random memory latency/backpressure,
// random redirects, and directed scenarios, checked against a queue-based
// reference model of the fetch stage.
module tb_f_prefetch_buffer;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        f_valid;
  logic [31:0] f_pc_o;
  logic [31:0] instr;
  logic        d_ready;
  logic        br_en;
  logic [31:0] br_addr;

  always #5 clock = ~clock;

  f_prefetch_buffer #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .f_valid(f_valid), .f_pc_o(f_pc_o), .instr(instr),
    .d_ready(d_ready), .br_en(br_en), .br_addr(br_addr)
  );

  // ---------------- environment / model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        pend[$];          // requests accepted by memory, in order
  logic [63:0] exp_q[$];         // expected decode queue: {pc, instr}
  logic [31:0] m_fetch_pc;       // expected next fetch address
  int          cyc = 0;

  int n_chk = 0;
  int n_err = 0;

  // stimulus knobs
  int          p_rdy, p_dr, p_br, lat_lo, lat_hi;
  bit          force_br;
  logic [31:0] force_addr;

  // directed observation helpers
  bit          prev_v;
  bit          prev_rdy;
  logic [31:0] prev_addr;
  int          pops;
  bit          track_first;
  logic [31:0] track_pc;
  bit          saw_zero;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Entered and left at posedge+1.
  task automatic step();
    bit          e_rv;
    bit          rsp_v;
    bit          dut_rv;
    logic [31:0] dut_addr;
    logic [31:0] tgt;
    logic [63:0] hd;
    int          nonstale;
    bit          do_pop;
    req_t        r;

    imem_req_ready = ($urandom_range(99) < p_rdy);
    d_ready        = ($urandom_range(99) < p_dr);
    br_en          = force_br || ($urandom_range(99) < p_br);
    br_addr        = force_br ? force_addr : $urandom();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end

    #3;
    nonstale = 0;
    foreach (pend[i]) if (!pend[i].stale) nonstale++;
    e_rv = !br_en && (pend.size() < MAX_OUT) && (exp_q.size() + nonstale < DEPTH);
    hd   = (exp_q.size() > 0) ? exp_q[0] : 64'h0;

    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    chk("req_addr",  imem_req_addr, m_fetch_pc);
    chk("f_valid",   32'(f_valid), 32'(exp_q.size() > 0));
    chk("f_pc",      f_pc_o, hd[63:32]);
    chk("instr",     instr,  hd[31:0]);
    if (prev_v && !prev_rdy && !br_en) begin
      chk("hold_valid", 32'(imem_req_valid), 32'd1);
      chk("hold_addr",  imem_req_addr, prev_addr);
    end
    if (f_valid && d_ready && !br_en) begin
      pops++;
      if (track_first) begin
        chk("first_pc", f_pc_o, track_pc);
        track_first = 1'b0;
      end
    end
    if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h0) saw_zero = 1'b1;

    rsp_v    = imem_rsp_valid;
    dut_rv   = imem_req_valid;
    dut_addr = imem_req_addr;
    prev_v   = imem_req_valid;
    prev_rdy = imem_req_ready;
    prev_addr = imem_req_addr;
    tgt      = br_addr & 32'hFFFF_FFFC;

    @(posedge clock);
    // reference model update
    if (br_en) begin
      exp_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      if (rsp_v) void'(pend.pop_front());
      m_fetch_pc = tgt;
    end else begin
      do_pop = (exp_q.size() > 0) && d_ready;
      if (do_pop) void'(exp_q.pop_front());
      if (rsp_v) begin
        r = pend.pop_front();
        if (!r.stale) exp_q.push_back({r.addr, mem_word(r.addr)});
      end
      if (e_rv && imem_req_ready) m_fetch_pc = m_fetch_pc + 32'd4;
    end
    // memory accepts whatever the DUT actually handed over
    if (dut_rv && imem_req_ready) begin
      r.addr  = dut_addr;
      r.due   = cyc + 1 + $urandom_range(lat_hi - 1, lat_lo - 1);
      r.stale = 1'b0;
      pend.push_back(r);
    end
    cyc++;
    #1;
  endtask

  task automatic set_knobs(int rdy, int dr, int br, int llo, int lhi);
    p_rdy = rdy; p_dr = dr; p_br = br; lat_lo = llo; lat_hi = lhi;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect(logic [31:0] a);
    force_br    = 1'b1;
    force_addr  = a;
    step();
    force_br    = 1'b0;
    track_first = 1'b1;
    track_pc    = a & 32'hFFFF_FFFC;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"},  imem_req_addr, RESET_PC);
    chk({tag, "_f_valid"},   32'(f_valid), 32'd0);
    chk({tag, "_f_pc"},      f_pc_o, 32'd0);
    chk({tag, "_instr"},     instr, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    d_ready = 1'b0; br_en = 1'b0; br_addr = '0;
    force_br = 1'b0; force_addr = '0;
    prev_v = 1'b0; prev_rdy = 1'b0; prev_addr = '0;
    pops = 0; track_first = 1'b0; track_pc = '0; saw_zero = 1'b0;
    m_fetch_pc = RESET_PC;
    set_knobs(100, 100, 0, 1, 1);

    #7;
    check_reset_outputs("rst");
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // back-to-back streaming, 1-cycle memory
    pops = 0;
    run(30);
    chk("throughput_pops", 32'(pops), 32'd28);

    // decode stalled: queue fills, requests stop
    set_knobs(100, 0, 0, 1, 1);
    run(20);
    chk("full_f_valid", 32'(f_valid), 32'd1);
    chk("full_no_req",  32'(imem_req_valid), 32'd0);
    set_knobs(100, 100, 0, 1, 1);
    run(10);

    // 3-cycle memory, redirect with two requests in flight
    set_knobs(100, 100, 0, 3, 3);
    for (int i = 0; i < 20 && pend.size() != 2; i++) step();
    chk("two_inflight", 32'(pend.size()), 32'd2);
    redirect(32'h0000_2003);
    run(15);
    chk("br_first_seen", 32'(track_first), 32'd0);

    // request stall then redirect during the stall
    set_knobs(100, 100, 0, 1, 1);
    run(5);
    set_knobs(0, 100, 0, 1, 1);
    run(5);
    redirect(32'h0000_3010);
    set_knobs(100, 100, 0, 1, 2);
    run(10);

    // address wrap at the top of the address space
    saw_zero = 1'b0;
    redirect(32'hFFFF_FFFD);
    run(8);
    chk("wrap_to_zero", 32'(saw_zero), 32'd1);

    // random traffic
    set_knobs(70, 70, 4, 1, 3);
    run(2500);
    set_knobs(80, 20, 3, 1, 4);
    run(1500);

    // asynchronous reset mid-stream
    set_knobs(100, 100, 0, 1, 1);
    run(7);
    #2;
    reset = 1'b1;
    imem_rsp_valid = 1'b0; br_en = 1'b0;
    #1;
    check_reset_outputs("midrst");
    pend.delete(); exp_q.delete();
    m_fetch_pc = RESET_PC; prev_v = 1'b0; track_first = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    pops = 0;
    run(30);
    chk("post_reset_pops", 32'(pops), 32'd28);
    set_knobs(60, 60, 5, 1, 3);
    run(500);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
